mac_pattern_detect_pipe: RTL and testbench

- Parametrised, pipelined multiply / multiply-accumulate unit with masked pattern detection on the result.
- Operand pair accepted under a valid qualifier; result, detect flag, sticky flag and saturating match counter are all registered.
- Sits in the DSP datapath as the general replacement for fixed-width multiply-and-compare blocks.
- Pattern and mask are run-time inputs, not hard constants.

---
 rtl/mac_pattern_detect_pipe.sv | 178 +++++++++++++++++
 tb/tb_mac_pattern_detect_pipe.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pattern_detect_pipe.sv
// -----------------------------------------------------------------------------
// mac_pattern_detect_pipe
//
// Three-stage pipelined multiply / multiply-accumulate with masked pattern
// detection on the value written into the result register.
//
//   S1: register a, b, acc_en, in_valid
//   S2: register the full product, extended to ACC_W (sign-extended if SIGNED)
//   S3: update result, pattern_detect, pattern_sticky, match_count
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   in_valid       qualifies a, b, acc_en this cycle
//   a, b           operands (IN_W bits)
//   acc_en         1 = accumulate product, 0 = load product
//   clr            synchronous clear of result/sticky/counter, applied at S3
//   pattern        compare value (sampled at S3, not pipelined)
//   mask           1 bits are don't-care in the compare (sampled at S3)
//   out_valid      result valid (in_valid delayed 3 cycles)
//   result         product or accumulated sum, modulo 2^ACC_W
//   pattern_detect masked match of the newly written result, qualified
//   pattern_sticky set on any detect since last clr/reset
//   match_count    saturating count of detects
//
// Optional feature (macro MAC_PATDET_PATTERN_B_EN):
//   pattern_b_detect  masked result equals masked ~pattern; same timing and
//                     clear rules as pattern_detect; also feeds sticky/count.
// -----------------------------------------------------------------------------
module mac_pattern_detect_pipe #(
    parameter int IN_W   = 16,
    parameter int ACC_W  = 40,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             acc_en,
    input  logic             clr,
    input  logic [ACC_W-1:0] pattern,
    input  logic [ACC_W-1:0] mask,
    output logic             out_valid,
    output logic [ACC_W-1:0] result,
    output logic             pattern_detect,
    output logic             pattern_sticky,
`ifdef MAC_PATDET_PATTERN_B_EN
    output logic             pattern_b_detect,
`endif
    output logic [CNT_W-1:0] match_count
);

    // The accumulator must hold the full product.
    generate
        if (ACC_W < 2 * IN_W) begin : g_width_check
            $error("mac_pattern_detect_pipe: ACC_W must be >= 2*IN_W");
        end
    endgenerate

    // ------------------------------------------------------------------ S1
    logic [IN_W-1:0] a_s1_reg;
    logic [IN_W-1:0] b_s1_reg;
    logic            acc_s1_reg;
    logic            v_s1_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_s1_reg   <= '0;
            b_s1_reg   <= '0;
            acc_s1_reg <= 1'b0;
            v_s1_reg   <= 1'b0;
        end else begin
            a_s1_reg   <= a;
            b_s1_reg   <= b;
            acc_s1_reg <= acc_en;
            v_s1_reg   <= in_valid;
        end
    end

    // ------------------------------------------------------------------ S2
    // Operands are extended to ACC_W before multiplying; since the exact
    // product fits in 2*IN_W <= ACC_W bits, the truncated ACC_W product is
    // exactly the (sign- or zero-) extended full product.
    logic [ACC_W-1:0] prod_ext;

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [ACC_W-1:0] a_ext;
            logic signed [ACC_W-1:0] b_ext;
            assign a_ext    = ACC_W'($signed(a_s1_reg));
            assign b_ext    = ACC_W'($signed(b_s1_reg));
            assign prod_ext = a_ext * b_ext;
        end else begin : g_unsigned
            assign prod_ext = ACC_W'(a_s1_reg) * ACC_W'(b_s1_reg);
        end
    endgenerate

    logic [ACC_W-1:0] prod_s2_reg;
    logic             acc_s2_reg;
    logic             v_s2_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_s2_reg <= '0;
            acc_s2_reg  <= 1'b0;
            v_s2_reg    <= 1'b0;
        end else begin
            prod_s2_reg <= prod_ext;
            acc_s2_reg  <= acc_s1_reg;
            v_s2_reg    <= v_s1_reg;
        end
    end

    // ------------------------------------------------------------------ S3
    // Compare is done on the value about to be written, so the detect flag
    // lines up with the result it describes.
    logic [ACC_W-1:0] result_next;
    logic             hit_a;
    logic             hit_b;
    logic             hit_any;

    always_comb begin
        result_next = acc_s2_reg ? (result + prod_s2_reg) : prod_s2_reg;
        hit_a       = ((result_next ^ pattern) & ~mask) == '0;
`ifdef MAC_PATDET_PATTERN_B_EN
        hit_b       = ((result_next ^ ~pattern) & ~mask) == '0;
`else
        hit_b       = 1'b0;
`endif
        hit_any     = hit_a | hit_b;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid      <= 1'b0;
            result         <= '0;
            pattern_detect <= 1'b0;
            pattern_sticky <= 1'b0;
            match_count    <= '0;
        end else begin
            // out_valid still follows a valid op that clr drops.
            out_valid <= v_s2_reg;
            if (clr) begin
                result         <= '0;
                pattern_detect <= 1'b0;
                pattern_sticky <= 1'b0;
                match_count    <= '0;
            end else if (v_s2_reg) begin
                result         <= result_next;
                pattern_detect <= hit_a;
                if (hit_any) begin
                    pattern_sticky <= 1'b1;
                    if (match_count != {CNT_W{1'b1}}) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                end
            end else begin
                // Invalid slot: result/sticky/count hold, detect is qualified.
                pattern_detect <= 1'b0;
            end
        end
    end

`ifdef MAC_PATDET_PATTERN_B_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_b_detect <= 1'b0;
        end else if (clr || !v_s2_reg) begin
            pattern_b_detect <= 1'b0;
        end else begin
            pattern_b_detect <= hit_b;
        end
    end
`endif

endmodule

// File: tb/tb_mac_pattern_detect_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for mac_pattern_detect_pipe (SIGNED=1, CNT_W=2 build).
// Stimulus pushes hand-computed expectations into a queue; a negedge monitor
// pops and compares whenever out_valid is high.
// -----------------------------------------------------------------------------
module tb_mac_pattern_detect_pipe;

    localparam int IN_W   = 16;
    localparam int ACC_W  = 40;
    localparam int SIGNED = 1;
    localparam int CNT_W  = 2;

`ifdef MAC_PATDET_PATTERN_B_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  a = '0;
    logic [IN_W-1:0]  b = '0;
    logic             acc_en = 1'b0;
    logic             clr = 1'b0;
    logic [ACC_W-1:0] pattern = '0;
    logic [ACC_W-1:0] mask = '0;
    logic             out_valid;
    logic [ACC_W-1:0] result;
    logic             pattern_detect;
    logic             pattern_sticky;
    logic [CNT_W-1:0] match_count;
`ifdef MAC_PATDET_PATTERN_B_EN
    logic             pattern_b_detect;
`endif

    mac_pattern_detect_pipe #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W),
        .SIGNED(SIGNED),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .a             (a),
        .b             (b),
        .acc_en        (acc_en),
        .clr           (clr),
        .pattern       (pattern),
        .mask          (mask),
        .out_valid     (out_valid),
        .result        (result),
        .pattern_detect(pattern_detect),
        .pattern_sticky(pattern_sticky),
`ifdef MAC_PATDET_PATTERN_B_EN
        .pattern_b_detect(pattern_b_detect),
`endif
        .match_count   (match_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             det;
        logic             detb;
        logic             sticky;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        clr      = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [IN_W-1:0] ia, input logic [IN_W-1:0] ib,
                         input logic iacc, input logic iclr,
                         input logic [ACC_W-1:0] er, input logic ed, input logic edb,
                         input logic es, input logic [CNT_W-1:0] ec, input bit push);
        exp_t e;
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        acc_en   = iacc;
        clr      = iclr;
        if (push) begin
            e.res = er; e.det = ed; e.detb = edb; e.sticky = es; e.cnt = ec;
            q.push_back(e);
        end
        step();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 result=%0h", result);
                end else begin
                    mon_e = q.pop_front();
                    chk("result", 64'(result), 64'(mon_e.res));
                    chk("pattern_detect", 64'(pattern_detect), 64'(mon_e.det));
                    chk("pattern_sticky", 64'(pattern_sticky), 64'(mon_e.sticky));
                    chk("match_count", 64'(match_count), 64'(mon_e.cnt));
`ifdef MAC_PATDET_PATTERN_B_EN
                    chk("pattern_b_detect", 64'(pattern_b_detect), 64'(mon_e.detb));
`endif
                    $display("txn result=%0h detect=%0b sticky=%0b count=%0d",
                             result, pattern_detect, pattern_sticky, match_count);
                end
            end else begin
                chk("detect_idle", 64'(pattern_detect), 64'd0);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_detect", 64'(pattern_detect), 64'd0);
        chk("rst_sticky", 64'(pattern_sticky), 64'd0);
        chk("rst_count", 64'(match_count), 64'd0);
        rst = 1'b1;
        idle(2);

        // Plain multiply: 6*6 = 36 matches pattern 36
        pattern = 40'd36; mask = '0;
        issue(16'd6, 16'd6, 1'b0, 1'b0, 40'd36, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
        idle(5);

        // Accumulate: 6, 22, 30; detect only on 30
        pattern = 40'd30; mask = '0;
        issue(16'd2, 16'd3, 1'b0, 1'b0, 40'd6,  1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        issue(16'd4, 16'd4, 1'b1, 1'b0, 40'd22, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        issue(16'd1, 16'd8, 1'b1, 1'b0, 40'd30, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        idle(5);

        // Signed: -3*5 = -15, masked compare on low byte 0xF1
        pattern = 40'hF1; mask = ~40'hFF;
        issue(16'hFFFD, 16'd5, 1'b0, 1'b0, 40'hFF_FFFF_FFF1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1);
        idle(5);

        // clr coincides with op1 at S3: op1 dropped, op2/op3 accumulate from 0
        pattern = '0; mask = '0;
        issue(16'd7, 16'd7, 1'b0, 1'b0, 40'd0,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        issue(16'd3, 16'd3, 1'b1, 1'b0, 40'd9,  1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        issue(16'd2, 16'd2, 1'b1, 1'b1, 40'd13, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        idle(4);
        // Invalid gap cycles hold result
        chk("gap_result", 64'(result), 64'd13);
        chk("gap_out_valid", 64'(out_valid), 64'd0);
        idle(2);
        chk("gap_result_hold", 64'(result), 64'd13);
        chk("gap_out_valid_hold", 64'(out_valid), 64'd0);

        // Clear on an empty pipeline, then saturating counter with all-ones mask
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_count", 64'(match_count), 64'd0);
        chk("clr_sticky", 64'(pattern_sticky), 64'd0);
        pattern = '0; mask = '1;
        issue(16'd1, 16'd1, 1'b0, 1'b0, 40'd1, 1'b1, DB_EN, 1'b1, 2'd1, 1'b1);
        issue(16'd1, 16'd1, 1'b0, 1'b0, 40'd1, 1'b1, DB_EN, 1'b1, 2'd2, 1'b1);
        issue(16'd1, 16'd1, 1'b0, 1'b0, 40'd1, 1'b1, DB_EN, 1'b1, 2'd3, 1'b1);
        issue(16'd1, 16'd1, 1'b0, 1'b0, 40'd1, 1'b1, DB_EN, 1'b1, 2'd3, 1'b1);
        issue(16'd1, 16'd1, 1'b0, 1'b0, 40'd1, 1'b1, DB_EN, 1'b1, 2'd3, 1'b1);
        idle(5);

        // Async reset with 3 ops in flight (op1 just reached S3)
        issue(16'd1, 16'd2, 1'b0, 1'b0, 40'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        issue(16'd1, 16'd3, 1'b0, 1'b0, 40'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        issue(16'd1, 16'd4, 1'b0, 1'b0, 40'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_result", 64'(result), 64'd0);
        chk("arst_detect", 64'(pattern_detect), 64'd0);
        chk("arst_sticky", 64'(pattern_sticky), 64'd0);
        chk("arst_count", 64'(match_count), 64'd0);
        #1 rst = 1'b1;
        idle(6);

`ifdef MAC_PATDET_PATTERN_B_EN
        // 15*17 = 0xFF matches ~0 on the low byte
        pattern = '0; mask = ~40'hFF;
        issue(16'd15, 16'd17, 1'b0, 1'b0, 40'hFF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
        idle(5);
`endif

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
